// File: rtl/clk_enable_gen.sv
// Multi-channel clock-enable generator: per-channel programmable divisors, lock-gated phase-aligned start.
// Optional fractional divisors when FRACTIONAL_EN is defined.
module clk_enable_gen #(
   parameter int NUM_CH  = 4,
   parameter int DIV_W   = 8,
   parameter int FRAC_W  = 16,
   parameter int DEF_DIV = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pll_locked,
   input  logic              sync,
   input  logic              cfg_we,
   input  logic [3:0]        cfg_ch,
   input  logic [DIV_W-1:0]  cfg_div,
   input  logic [FRAC_W-1:0] cfg_frac,
   output logic [NUM_CH-1:0] ce,
   output logic              ready
);

`ifdef FRACTIONAL_EN
   // One extra bit so a full divisor plus a fractional carry still fits.
   localparam int CNT_W = DIV_W + 1;
`else
   localparam int CNT_W = DIV_W;
   logic w_frac_unused;
   assign w_frac_unused = ^cfg_frac;
`endif

   logic r_lock_meta;
   logic r_lock_s;
   logic r_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lock_meta <= 1'b0;
         r_lock_s    <= 1'b0;
         r_ready     <= 1'b0;
      end else begin
         r_lock_meta <= pll_locked;
         r_lock_s    <= r_lock_meta;
         r_ready     <= r_lock_s;
      end
   end

   assign ready = r_ready;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         logic [CNT_W-1:0] r_cnt;
         logic [DIV_W-1:0] r_div_sh;
         logic             r_ce;
         logic             w_wr;
         logic             w_clear;
         logic [CNT_W-1:0] w_reload;

         // Matching the channel index also rejects any index >= NUM_CH.
         assign w_wr    = cfg_we && (cfg_ch == 4'(gi));
         assign w_clear = !r_lock_s || sync;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_div_sh <= DIV_W'(DEF_DIV);
            end else if (w_wr) begin
               r_div_sh <= cfg_div;
            end
         end

`ifdef FRACTIONAL_EN
         logic [FRAC_W-1:0] r_frac_sh;
         logic [FRAC_W-1:0] r_acc;
         logic [FRAC_W:0]   w_sum;

         assign w_sum    = {1'b0, r_acc} + {1'b0, r_frac_sh};
         assign w_reload = {1'b0, r_div_sh} + CNT_W'(w_sum[FRAC_W]);

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_frac_sh <= '0;
            end else if (w_wr) begin
               r_frac_sh <= cfg_frac;
            end
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_acc <= '0;
            end else if (w_clear) begin
               r_acc <= '0;
            end else if (r_cnt == '0) begin
               r_acc <= w_sum[FRAC_W-1:0];
            end
         end
`else
         assign w_reload = r_div_sh;
`endif

         // Stopped or resyncing channels park at terminal so they all fire on the same edge.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_cnt <= '0;
               r_ce  <= 1'b0;
            end else if (w_clear) begin
               r_cnt <= '0;
               r_ce  <= 1'b0;
            end else if (r_cnt == '0) begin
               r_cnt <= w_reload;
               r_ce  <= 1'b1;
            end else begin
               r_cnt <= r_cnt - 1'b1;
               r_ce  <= 1'b0;
            end
         end

         assign ce[gi] = r_ce;
      end
   endgenerate

endmodule

// File: tb/tb_clk_enable_gen.sv
// Directed bench for clk_enable_gen: vector table for lock/sync sequencing plus hand-built
// sequences for divisor programming, write timing, fractional periods and async reset.
module tb_clk_enable_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        pll_locked;
   logic        sync;
   logic        cfg_we;
   logic [3:0]  cfg_ch;
   logic [7:0]  cfg_div;
   logic [15:0] cfg_frac;
   logic [3:0]  ce;
   logic        ready;

   int n_tests = 0;
   int n_fail  = 0;

   clk_enable_gen #(.NUM_CH(4), .DIV_W(8), .FRAC_W(16), .DEF_DIV(1)) dut (
      .clk(clk), .rst(rst), .pll_locked(pll_locked), .sync(sync),
      .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_frac(cfg_frac),
      .ce(ce), .ready(ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       lock;
      logic       sy;
      logic [3:0] exp_ce;
      logic       exp_ready;
   } vec_t;

   vec_t tbl[22];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; pll_locked = 1'b0; sync = 1'b0;
      cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_frac = '0;
      step(); step();
      rst = 1'b0;
      step();
   endtask

   task automatic write_ch(input logic [3:0] ch, input logic [7:0] dv, input logic [15:0] fr);
      cfg_we = 1'b1; cfg_ch = ch; cfg_div = dv; cfg_frac = fr;
      step();
      cfg_we = 1'b0;
   endtask

   initial begin
      logic [3:0] exp_v;
      int next_p;
      int per;
      int pulses;

      // Default divisor 1: lock start, alternate, sync, lock drop, relock, held sync.
      tbl[0]  = '{1'b1, 1'b0, 4'h0, 1'b0};
      tbl[1]  = '{1'b1, 1'b0, 4'h0, 1'b0};
      tbl[2]  = '{1'b1, 1'b0, 4'hF, 1'b1};
      tbl[3]  = '{1'b1, 1'b0, 4'h0, 1'b1};
      tbl[4]  = '{1'b1, 1'b0, 4'hF, 1'b1};
      tbl[5]  = '{1'b1, 1'b1, 4'h0, 1'b1};
      tbl[6]  = '{1'b1, 1'b0, 4'hF, 1'b1};
      tbl[7]  = '{1'b1, 1'b0, 4'h0, 1'b1};
      tbl[8]  = '{1'b1, 1'b0, 4'hF, 1'b1};
      tbl[9]  = '{1'b0, 1'b0, 4'h0, 1'b1};
      tbl[10] = '{1'b0, 1'b0, 4'hF, 1'b1};
      tbl[11] = '{1'b0, 1'b0, 4'h0, 1'b0};
      tbl[12] = '{1'b1, 1'b0, 4'h0, 1'b0};
      tbl[13] = '{1'b1, 1'b0, 4'h0, 1'b0};
      tbl[14] = '{1'b1, 1'b0, 4'hF, 1'b1};
      tbl[15] = '{1'b1, 1'b0, 4'h0, 1'b1};
      tbl[16] = '{1'b1, 1'b1, 4'h0, 1'b1};
      tbl[17] = '{1'b1, 1'b1, 4'h0, 1'b1};
      tbl[18] = '{1'b1, 1'b1, 4'h0, 1'b1};
      tbl[19] = '{1'b1, 1'b1, 4'h0, 1'b1};
      tbl[20] = '{1'b1, 1'b1, 4'h0, 1'b1};
      tbl[21] = '{1'b1, 1'b0, 4'hF, 1'b1};

      do_reset();
      check("reset_ce", 32'(ce), 32'h0);
      check("reset_ready", 32'(ready), 32'h0);

      for (int i = 0; i < 22; i++) begin
         pll_locked = tbl[i].lock;
         sync       = tbl[i].sy;
         step();
         check($sformatf("vec%0d_ce", i), 32'(ce), 32'(tbl[i].exp_ce));
         check($sformatf("vec%0d_ready", i), 32'(ready), 32'(tbl[i].exp_ready));
      end
      sync = 1'b0;

      // Divisors 3/0/7/1 written before lock; mid-run ch0 rewrite and an out-of-range write.
      do_reset();
      write_ch(4'd0, 8'd3, 16'h0);
      write_ch(4'd1, 8'd0, 16'h0);
      write_ch(4'd2, 8'd7, 16'h0);
      pll_locked = 1'b1;
      step(); step();
      for (int k = 0; k < 24; k++) begin
         step();
         exp_v[0] = (k <= 8) ? (k % 4 == 0) : (k >= 12 && k % 2 == 0);
         exp_v[1] = 1'b1;
         exp_v[2] = (k % 8 == 0);
         exp_v[3] = (k % 2 == 0);
         check($sformatf("div_k%0d_ce", k), 32'(ce), 32'(exp_v));
         if (k == 0) check("div_first_ready", 32'(ready), 32'h1);
         if (k == 2) begin
            cfg_we = 1'b1; cfg_ch = 4'd9; cfg_div = 8'd2;
         end
         if (k == 8) begin
            cfg_we = 1'b1; cfg_ch = 4'd0; cfg_div = 8'd1;
         end
         if (k == 3 || k == 9) cfg_we = 1'b0;
      end

      // div=2 with half-step fraction: 3,4 alternation when fractional, flat 3 otherwise.
      do_reset();
      for (int c = 0; c < 4; c++) write_ch(4'(c), 8'd2, 16'h8000);
      pll_locked = 1'b1;
      step(); step();
      next_p = 0;
      per    = 3;
      pulses = 0;
      for (int k = 0; k < 24; k++) begin
         step();
         exp_v = (k == next_p) ? 4'hF : 4'h0;
         if (k == next_p) begin
            pulses++;
            next_p = next_p + per;
`ifdef FRACTIONAL_EN
            per = (per == 3) ? 4 : 3;
`endif
         end
         check($sformatf("frac_k%0d_ce", k), 32'(ce), 32'(exp_v));
      end
`ifdef FRACTIONAL_EN
      check("frac_pulse_count", 32'(pulses), 32'd7);
`else
      check("int_pulse_count", 32'(pulses), 32'd8);
`endif

      // Asynchronous reset mid-cycle clears outputs without waiting for an edge.
      #3;
      rst = 1'b1;
      #1;
      check("async_rst_ce", 32'(ce), 32'h0);
      check("async_rst_ready", 32'(ready), 32'h0);
      step();
      rst = 1'b0;
      step();
      check("post_rst_ready", 32'(ready), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/clk_enable_gen.md
# clk_enable_gen

Multi-channel clock-enable generator that sits directly behind the system PLL and derives all slow video, CPU and peripheral timing strobes from one fast master clock as single-cycle enable pulses. It replaces per-rate PLL outputs and hard-coded dividers with runtime-programmable integer or fractional divisors per channel. Lock-gated start guarantees that all channels begin phase-aligned, and a resync input re-establishes alignment on demand.

## Interface
- NUM_CH, 4: number of enable channels (1–16).
- DIV_W, 8: integer divisor width; channel period is div+1 clocks.
- FRAC_W, 16: fractional accumulator width (used only with FRACTIONAL_EN).
- DEF_DIV, 1: reset value of every channel's integer divisor.

Ports:
- clk  in  1  master clock (PLL output).
- rst  in  1  asynchronous, active-high reset.
- pll_locked  in  1  PLL lock, asynchronous to clk.
- sync  in  1  resync request, sampled each clk.
- cfg_we  in  1  divisor write strobe.
- cfg_ch  in  4  channel index for write.
- cfg_div  in  DIV_W  integer divisor.
- cfg_frac  in  FRAC_W  fractional increment (ignored without FRACTIONAL_EN).
- ce  out  NUM_CH  one-cycle enable pulse per channel.
- ready  out  1  high while synced lock is high and channels are running.

## Operation
- pll_locked passes through a 2-flop synchroniser to produce lock_s; run = lock_s.
- Per-channel state: cnt[DIV_W], shadow div_sh[DIV_W], frac_sh[FRAC_W], acc[FRAC_W], registered ce bit.
- While run=0: cnt=0, acc=0, ce=0, ready=0. Shadows keep their values and stay writable.
- While run=1, on each clk:
  - If cnt==0: ce<=1 and cnt<=div_sh (+1 when the fractional carry is set).
  - Otherwise: ce<=0 and cnt<=cnt-1.
- div=0 gives ce high on every cycle.
- Writes: when cfg_we=1 and cfg_ch<NUM_CH, div_sh<=cfg_div and frac_sh<=cfg_frac. Writes with cfg_ch>=NUM_CH are ignored.
- A new divisor takes effect at the first terminal reload strictly after the write cycle. A write in the same cycle as a terminal does not affect that reload.
- sync=1 while run=1 forces all cnt<=0, acc<=0 and ce<=0. All channels then pulse together on the following edge. sync held high keeps ce at 0. sync is ignored while run=0.
- ready<=lock_s (registered).

## Timing
- Reset values: ce=0, ready=0, cnt=0, acc=0, div_sh=DEF_DIV, frac_sh=0, synchroniser flops=0.
- pll_locked rises before edge E0 (setup met):
  - lock_s is high after E1.
  - ready and all ce bits go high together at E2.
  - This makes the first pulse of every channel coincident.
- pll_locked falls: ready and all ce are low from E2 onward, and any partial periods are discarded.
- sync high at edge S: ce=0 after S, and all ce=1 after S+1.
- Steady state: ce period is exactly div_sh+1 clocks with a 1-clock high time. Output latency is registered (no combinational path from inputs to ce or ready).
- cnt is unsigned with no wrap beyond the reload; the maximum period is 2^DIV_W clocks (plus 1 on a fractional carry).
- Reset mid-operation clears everything immediately (asynchronous assertion). Deassertion is sampled on the next clk, and running resumes only after lock re-synchronises.

## Configuration
- FRACTIONAL_EN defined:
  - At each terminal, {carry, acc} <= acc + frac_sh.
  - When carry=1, the next reload uses div_sh+1.
  - Average period is div_sh+1+frac_sh/2^FRAC_W clocks, with worst-case jitter of 1 clock.
- Not defined: acc, frac_sh and the adder are not instantiated, cfg_frac is ignored, and periods are strictly integer.

## Test plan
- Reset, then pll_locked=1, all div=DEF_DIV=1 -> ready and ce=4'b1111 at the 2nd edge after lock is seen; then ce alternates 1111/0000 each clock.
- ch0 div=3, ch1 div=0, ch2 div=7 written before lock -> periods 4, 1 and 8 clocks; all first pulses coincide with ready.
- ch0 running div=3, write div=1 in the same cycle as a ch0 pulse -> next gap is 4 clocks, then 2-clock periods thereafter. A write with cfg_ch=9 changes nothing.
- Channels misaligned by writes, then sync pulsed for 1 cycle -> ce=0 next edge, ce=all-ones the edge after; holding sync 5 cycles -> ce=0 throughout.
- pll_locked dropped mid-period -> ready and ce low within 2 clocks; relock -> aligned restart as in the first scenario. Async rst asserted mid-operation -> all outputs 0 immediately.
- FRACTIONAL_EN with div=2, frac=0x8000 (FRAC_W=16) -> periods alternate 3,4,3,4 clocks (7 pulses per 24 clocks over 1,000 pulses ±1). Without the macro -> constant period 3.
